matrix_result_display: RTL and testbench
========================================

MATRIX_RESULT_DISPLAY -- requirements
Module: matrix_result_display

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 10000000: clock cycles each result element is held on the display (legal range 2..2^24-1).
REQ-002 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a result word is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port res_hi, input, 8 bits: packed {r11[3:0], r12[3:0]}.
REQ-007 The block SHALL have port res_lo, input, 8 bits: packed {r21[3:0], r22[3:0]}.
REQ-008 The block SHALL have port err_in, input, 1 bit: operand-range error accompanying the word.
REQ-009 The block SHALL have port seg, output, 7 bits: active-high segments {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port dp, output, 1 bit: decimal point, lit while a captured error is shown.
REQ-011 The block SHALL have port elem_idx, output, 2 bits: element shown (0=r11, 1=r12, 2=r21, 3=r22).
REQ-012 The block SHALL have port busy, output, 1 bit: high in SHOW.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and SHOW.
REQ-014 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; on that edge the block captures res_hi, res_lo and err_in, and the FSM enters SHOW with elem_idx=0 and the dwell counter=0.
REQ-015 In IDLE, in_ready SHALL be 1, seg SHALL be 0, dp SHALL be 0 and busy SHALL be 0.
REQ-016 In SHOW, seg SHALL be valid on the cycle after the transfer (one-cycle latency) and SHALL be the hex glyph of the selected captured nibble: 0-9 and A,b,C,d,E,F.
REQ-017 While the captured error bit is 1, seg SHALL show glyph E (7'b1111001) for every element and dp SHALL be 1.
REQ-018 The dwell counter SHALL increment every SHOW cycle; when it equals DWELL_CYCLES-1, it SHALL clear and elem_idx SHALL advance by 1.
REQ-019 When elem_idx=3 reaches the dwell limit, the next action SHALL follow REQ-024/REQ-025.
REQ-020 The block SHALL treat nibble values 9..15 as displayable; it SHALL perform no saturation or range check on result data.
REQ-021 In_valid held high with in_ready low SHALL have no effect; the word is not captured.
REQ-022 Captured data SHALL be unaffected by input changes outside a transfer edge.

Reset
REQ-023 While reset is 1 at a clock edge, the block SHALL enter IDLE with seg=0, dp=0, elem_idx=0, busy=0, in_ready=1, the dwell counter=0 and the captured registers=0; this holds even mid-SHOW and even with in_valid=1, and reset SHALL take priority over a transfer.

Configuration
REQ-024 With MATRIX_DISP_LOOP_EN defined, elem_idx SHALL wrap 3->0 and SHOW SHALL repeat indefinitely; in_ready SHALL also be 1 in SHOW, and a transfer in SHOW SHALL restart at elem_idx=0 with the new data and the dwell counter cleared.
REQ-025 Without MATRIX_DISP_LOOP_EN, the FSM SHALL return to IDLE after the elem_idx=3 dwell; in_ready SHALL be 0 throughout SHOW.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, SHOW), the element-index constants, the 16-entry glyph table and the GLYPH_ERR constant.
REQ-027 The hex-to-seven-segment conversion SHALL be a combinational sub-module named hex_to_seg7.

Verification (DWELL_CYCLES=4)
REQ-028 Reset, then transfer res_hi=8'h84, res_lo=8'h20 with err_in=0 -> seg shows 8, 4, 2, 0 for 4 cycles each; elem_idx steps 0..3; with no macro, idle at cycle 17 with seg=0.
REQ-029 Transfer with err_in=1 -> seg=E and dp=1 for all 16 cycles.
REQ-030 Hold in_valid=1 during SHOW (no macro) -> in_ready=0 and no recapture; the next transfer is accepted in the first IDLE cycle.
REQ-031 Assert reset at cycle 6 of SHOW -> next cycle: IDLE, seg=0, elem_idx=0, in_ready=1.
REQ-032 With the macro, after 16 cycles elem_idx wraps to 0 and the sequence repeats; a new transfer at cycle 10 restarts at elem_idx=0 with the new data.
REQ-033 Transfer res_hi=8'hAF -> glyphs A, F are shown (7'b1110111, 7'b1110001).

Source files
------------

// File: rtl/matrix_result_display_pkg.sv
// Shared types and constants for the matrix result display: FSM states,
// element indices and the seven-segment glyph set {g,f,e,d,c,b,a}.
package matrix_result_display_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam logic [1:0] ELEM_R11 = 2'd0;
    localparam logic [1:0] ELEM_R12 = 2'd1;
    localparam logic [1:0] ELEM_R21 = 2'd2;
    localparam logic [1:0] ELEM_R22 = 2'd3;

    localparam logic [6:0] GLYPH_ERR = 7'b1111001;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Picks the captured nibble for an element: r11, r12 from hi, r21, r22 from lo.
    function automatic logic [3:0] select_nibble(input logic [7:0] hi,
                                                 input logic [7:0] lo,
                                                 input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            ELEM_R11: nib = hi[7:4];
            ELEM_R12: nib = hi[3:0];
            ELEM_R21: nib = lo[7:4];
            ELEM_R22: nib = lo[3:0];
            default:  nib = 4'd0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/matrix_result_display_hex_to_seg7.sv
// Combinational hex nibble to seven-segment glyph decoder.
module hex_to_seg7
    import matrix_result_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/matrix_result_display.sv
// Cycles the four captured 2x2 result nibbles across a seven-segment display.
// Define MATRIX_DISP_LOOP_EN to repeat the sequence and accept new words while showing.
module matrix_result_display
    import matrix_result_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 10000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] res_hi,
    input  logic [7:0] res_lo,
    input  logic       err_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] elem_idx,
    output logic       busy
);

`ifdef MATRIX_DISP_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    localparam logic [23:0] DWELL_LAST = 24'(DWELL_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [23:0] r_cnt;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic        r_err;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        r_busy;
    logic        r_ready;

    state_t      w_state_next;
    logic [1:0]  w_idx_next;
    logic [23:0] w_cnt_next;
    logic [7:0]  w_hi_next;
    logic [7:0]  w_lo_next;
    logic        w_err_next;
    logic [6:0]  w_seg_next;
    logic        w_dp_next;
    logic        w_busy_next;
    logic        w_ready_next;
    logic        w_xfer;
    logic        w_dwell_done;
    logic [3:0]  w_nibble;
    logic [6:0]  w_glyph;

    assign w_xfer       = in_valid & r_ready;
    assign w_dwell_done = (r_cnt == DWELL_LAST);

    // State, capture and registered-output update; reset beats a transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= ELEM_R11;
            r_cnt   <= 24'd0;
            r_hi    <= 8'd0;
            r_lo    <= 8'd0;
            r_err   <= 1'b0;
            r_seg   <= 7'd0;
            r_dp    <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_err   <= w_err_next;
            r_seg   <= w_seg_next;
            r_dp    <= w_dp_next;
            r_busy  <= w_busy_next;
            r_ready <= w_ready_next;
        end
    end

    // Next-state: capture on transfer, then step elements every dwell period.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_err_next   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_next = ST_SHOW;
                    w_idx_next   = ELEM_R11;
                    w_cnt_next   = 24'd0;
                    w_hi_next    = res_hi;
                    w_lo_next    = res_lo;
                    w_err_next   = err_in;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (w_xfer) begin
                    w_idx_next   = ELEM_R11;
                    w_cnt_next   = 24'd0;
                    w_hi_next    = res_hi;
                    w_lo_next    = res_lo;
                    w_err_next   = err_in;
                end else if (w_dwell_done) begin
                    w_cnt_next = 24'd0;
                    if (r_idx == ELEM_R22) begin
                        w_idx_next = ELEM_R11;
                        if (LOOP_EN) begin
                            w_state_next = ST_SHOW;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_idx_next = r_idx + 2'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = ELEM_R11;
                w_cnt_next   = 24'd0;
            end
        endcase
    end

    assign w_nibble = select_nibble(w_hi_next, w_lo_next, w_idx_next);

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    // Output decode from the upcoming state so outputs land with their state.
    always_comb begin
        w_seg_next   = 7'd0;
        w_dp_next    = 1'b0;
        w_busy_next  = 1'b0;
        w_ready_next = 1'b1;
        if (w_state_next == ST_SHOW) begin
            w_seg_next   = w_err_next ? GLYPH_ERR : w_glyph;
            w_dp_next    = w_err_next;
            w_busy_next  = 1'b1;
            w_ready_next = LOOP_EN;
        end else begin
            w_seg_next   = 7'd0;
            w_dp_next    = 1'b0;
            w_busy_next  = 1'b0;
            w_ready_next = 1'b1;
        end
    end

    assign seg      = r_seg;
    assign dp       = r_dp;
    assign elem_idx = r_idx;
    assign busy     = r_busy;
    assign in_ready = r_ready;

endmodule

// File: tb/tb_matrix_result_display.sv
// Scoreboard bench for matrix_result_display with DWELL_CYCLES=4.
module tb_matrix_result_display;

    typedef struct packed {
        logic [63:0] tag;
        logic [6:0]  seg;
        logic        dp;
        logic [1:0]  idx;
        logic        busy;
        logic        rdy;
    } exp_t;

`ifdef MATRIX_DISP_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    // Hand-written glyphs {g,f,e,d,c,b,a} for 0..F.
    localparam logic [6:0] G [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] res_hi = 8'd0;
    logic [7:0] res_lo = 8'd0;
    logic       err_in = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] elem_idx;
    logic       busy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    matrix_result_display #(.DWELL_CYCLES(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .err_in   (err_in),
        .seg      (seg),
        .dp       (dp),
        .elem_idx (elem_idx),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    function automatic exp_t exp_idle(input logic [63:0] tag);
        exp_t e;
        e.tag = tag; e.seg = 7'd0; e.dp = 1'b0; e.idx = 2'd0; e.busy = 1'b0; e.rdy = 1'b1;
        return e;
    endfunction

    // k is the 1-based cycle count after the transfer edge.
    function automatic exp_t exp_show(input logic [63:0] tag, input logic [7:0] hi,
                                      input logic [7:0] lo, input logic err, input int k);
        exp_t e;
        logic [3:0] nib;
        logic [1:0] idx;
        idx = 2'(((k - 1) / 4) % 4);
        case (idx)
            2'd0:    nib = hi[7:4];
            2'd1:    nib = hi[3:0];
            2'd2:    nib = lo[7:4];
            default: nib = lo[3:0];
        endcase
        e.tag = tag; e.idx = idx; e.busy = 1'b1; e.rdy = LOOP;
        e.seg = err ? 7'b1111001 : G[nib];
        e.dp  = err;
        return e;
    endfunction

    task automatic cyc(input exp_t e);
        @(posedge clock);
        #1;
        q.push_back(e);
    endtask

    task automatic chk(input logic [63:0] tag, input string what, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %0s.%0s at %0t: got %0h, expected %0h", tag, what, $time, act, req);
        end
    endtask

    // Monitor: the display is live every cycle, so compare one expectation per cycle.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "seg", int'(seg), int'(e.seg));
            chk(e.tag, "dp", int'(dp), int'(e.dp));
            chk(e.tag, "idx", int'(elem_idx), int'(e.idx));
            chk(e.tag, "busy", int'(busy), int'(e.busy));
            chk(e.tag, "rdy", int'(in_ready), int'(e.rdy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(exp_idle("reset"));
        cyc(exp_idle("reset"));
        reset = 1'b0;
        cyc(exp_idle("idle"));

        // Basic sequence 8,4,2,0; inputs change after the transfer
        res_hi = 8'h84; res_lo = 8'h20; err_in = 1'b0; in_valid = 1'b1;
        cyc(exp_show("basic", 8'h84, 8'h20, 1'b0, 1));
        in_valid = 1'b0; res_hi = 8'hFF; res_lo = 8'hFF; err_in = 1'b1;
        for (int k = 2; k <= 16; k++) cyc(exp_show("basic", 8'h84, 8'h20, 1'b0, k));
        if (LOOP) begin
            for (int k = 17; k <= 20; k++) cyc(exp_show("wrap", 8'h84, 8'h20, 1'b0, k));
            reset = 1'b1;
            cyc(exp_idle("rst_loop"));
            reset = 1'b0;
        end else begin
            cyc(exp_idle("end17"));
        end

        // Error word: E with dp on every element
        res_hi = 8'h12; res_lo = 8'h34; err_in = 1'b1; in_valid = 1'b1;
        cyc(exp_show("err", 8'h12, 8'h34, 1'b1, 1));
        in_valid = 1'b0; err_in = 1'b0;
        for (int k = 2; k <= 16; k++) cyc(exp_show("err", 8'h12, 8'h34, 1'b1, k));
        if (LOOP) begin
            reset = 1'b1;
            cyc(exp_idle("rst_loop"));
            reset = 1'b0;
        end else begin
            cyc(exp_idle("err_end"));
        end

        if (!LOOP) begin
            // Held in_valid during SHOW: no recapture, accepted in first IDLE cycle
            res_hi = 8'hAF; res_lo = 8'h13; in_valid = 1'b1;
            cyc(exp_show("hold", 8'hAF, 8'h13, 1'b0, 1));
            res_hi = 8'h9B; res_lo = 8'hC6;
            for (int k = 2; k <= 16; k++) cyc(exp_show("hold", 8'hAF, 8'h13, 1'b0, k));
            cyc(exp_idle("hold_idl"));
            cyc(exp_show("hold2", 8'h9B, 8'hC6, 1'b0, 1));
            in_valid = 1'b0;
            for (int k = 2; k <= 16; k++) cyc(exp_show("hold2", 8'h9B, 8'hC6, 1'b0, k));
            cyc(exp_idle("hold_end"));
        end else begin
            // Restart at cycle 10 with new data
            res_hi = 8'hAF; res_lo = 8'h13; in_valid = 1'b1;
            cyc(exp_show("restart", 8'hAF, 8'h13, 1'b0, 1));
            in_valid = 1'b0;
            for (int k = 2; k <= 10; k++) cyc(exp_show("restart", 8'hAF, 8'h13, 1'b0, k));
            res_hi = 8'h9B; res_lo = 8'hC6; in_valid = 1'b1;
            cyc(exp_show("restart2", 8'h9B, 8'hC6, 1'b0, 1));
            in_valid = 1'b0;
            for (int k = 2; k <= 20; k++) cyc(exp_show("restart2", 8'h9B, 8'hC6, 1'b0, k));
        end

        // Reset during cycle 6 of SHOW, with in_valid high
        res_hi = 8'h5D; res_lo = 8'h7E; in_valid = 1'b1;
        cyc(exp_show("midrst", 8'h5D, 8'h7E, 1'b0, 1));
        in_valid = 1'b0;
        for (int k = 2; k <= 6; k++) cyc(exp_show("midrst", 8'h5D, 8'h7E, 1'b0, k));
        reset = 1'b1; in_valid = 1'b1;
        cyc(exp_idle("midrst_i"));
        reset = 1'b0; in_valid = 1'b0;
        cyc(exp_idle("post_rst"));

        // Remaining digits 5,d,7,E through a full pass
        in_valid = 1'b1;
        cyc(exp_show("digits", 8'h5D, 8'h7E, 1'b0, 1));
        in_valid = 1'b0;
        for (int k = 2; k <= 16; k++) cyc(exp_show("digits", 8'h5D, 8'h7E, 1'b0, k));

        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
